// File: rtl/multi_line_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_pkg
// Purpose  : Shared defaults and width/slice helpers for the line buffer.
// Revision : 1.0 - initial release
// ============================================================================
package line_buffer_pkg;

   localparam int c_default_dw = 8;
   localparam int c_default_w  = 64;
   localparam int c_default_h  = 64;
   localparam int c_default_k  = 3;

   function automatic int col_w(input int w);
      return $clog2(w);
   endfunction

   function automatic int row_w(input int h);
      return $clog2(h);
   endfunction

   // LSB of tap j inside the packed taps vector
   function automatic int tap_lsb(input int j, input int dw);
      return j * dw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_line_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_line_buffer_if
// Purpose  : Pixel stream in / vertical tap column out bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_line_buffer_if
   import line_buffer_pkg::*;
#(
   parameter int DW = c_default_dw,
   parameter int W  = c_default_w,
   parameter int H  = c_default_h,
   parameter int K  = c_default_k
);
   logic                   sof_in;
   logic                   valid_in;
   logic [DW-1:0]          pixel_in;
   logic                   valid_out;
   logic [K*DW-1:0]        taps_out;
   logic [col_w(W)-1:0]    col_out;
   logic [row_w(H)-1:0]    row_out;
   logic                   rows_ready_out;
   logic                   eol_out;
   logic                   eof_out;

   modport master (
      output sof_in, valid_in, pixel_in,
      input  valid_out, taps_out, col_out, row_out, rows_ready_out, eol_out, eof_out
   );

   modport slave (
      input  sof_in, valid_in, pixel_in,
      output valid_out, taps_out, col_out, row_out, rows_ready_out, eol_out, eof_out
   );
endinterface
`default_nettype wire

// File: rtl/multi_line_buffer_lb_row_ram.sv
`default_nettype none
// ============================================================================
// Module   : lb_row_ram
// Purpose  : One image row of storage, sync write / async read, no reset.
// Revision : 1.0 - initial release
// ============================================================================
module lb_row_ram
   import line_buffer_pkg::*;
#(
   parameter int DW = c_default_dw,
   parameter int W  = c_default_w
) (
   input  wire logic                clk,
   input  wire logic                we,
   input  wire logic [col_w(W)-1:0] addr,
   input  wire logic [DW-1:0]       wdata,
   output logic      [DW-1:0]       rdata
);
   logic [DW-1:0] r_mem [W];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
   end

   assign rdata = r_mem[addr];
endmodule
`default_nettype wire

// File: rtl/multi_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : multi_line_buffer
// Purpose  : K-row sliding line buffer emitting a registered K-tap column.
//            MULTI_LINE_BUFFER_BORDER_REPLICATE_EN: replicate top row instead
//            of zero padding for taps above the frame.
// Revision : 1.0 - initial release
// ============================================================================
module multi_line_buffer
   import line_buffer_pkg::*;
#(
   parameter int DW = c_default_dw,
   parameter int W  = c_default_w,
   parameter int H  = c_default_h,
   parameter int K  = c_default_k
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   multi_line_buffer_if.slave bus
);
   localparam int c_col_w  = col_w(W);
   localparam int c_row_w  = row_w(H);
   localparam int c_fill_w = $clog2(K);

   localparam logic [c_col_w-1:0]  c_col_last  = c_col_w'(W - 1);
   localparam logic [c_row_w-1:0]  c_row_last  = c_row_w'(H - 1);
   localparam logic [c_fill_w-1:0] c_fill_full = c_fill_w'(K - 1);

   logic [c_col_w-1:0]  r_col, w_col, w_col_nxt;
   logic [c_row_w-1:0]  r_row, w_row, w_row_nxt;
   logic [c_fill_w-1:0] r_fill, w_fill, w_fill_nxt;
   logic                w_eol, w_eof;

   logic [DW-1:0]       w_rd  [K-1];
   logic [DW-1:0]       w_raw [K];
   logic [K*DW-1:0]     w_taps;

   logic                r_valid_out;
   logic [K*DW-1:0]     r_taps;
   logic [c_col_w-1:0]  r_col_out;
   logic [c_row_w-1:0]  r_row_out;
   logic                r_rows_ready;
   logic                r_eol;
   logic                r_eof;

   // sof forces this pixel to (0,0); fill tracks min(row, K-1) for masking
   always_comb begin
      w_col      = bus.sof_in ? '0 : r_col;
      w_row      = bus.sof_in ? '0 : r_row;
      w_fill     = bus.sof_in ? '0 : r_fill;
      w_eol      = (w_col == c_col_last);
      w_eof      = w_eol && (w_row == c_row_last);
      w_col_nxt  = w_eol ? '0 : w_col + 1'b1;
      w_row_nxt  = w_row;
      w_fill_nxt = w_fill;
      if (w_eof) begin
         w_row_nxt  = '0;
         w_fill_nxt = '0;
      end else if (w_eol) begin
         w_row_nxt = w_row + 1'b1;
         if (w_fill != c_fill_full) begin
            w_fill_nxt = w_fill + 1'b1;
         end
      end
   end

   // Row 0 is the oldest; every write shifts the column up by one row
   generate
      for (genvar gi = 0; gi < K - 1; gi++) begin : g_row
         logic [DW-1:0] w_wdata;
         if (gi == K - 2) begin : g_newest
            assign w_wdata = bus.pixel_in;
         end else begin : g_shift
            assign w_wdata = w_rd[gi+1];
         end
         lb_row_ram #(
            .DW (DW),
            .W  (W)
         ) u_ram (
            .clk   (clk),
            .we    (bus.valid_in),
            .addr  (w_col),
            .wdata (w_wdata),
            .rdata (w_rd[gi])
         );
      end
   endgenerate

`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
   logic [c_fill_w-1:0] w_rep_idx;
   assign w_rep_idx = c_fill_full - w_fill;
`endif

   always_comb begin
      for (int j = 0; j < K - 1; j++) begin
         w_raw[j] = w_rd[j];
      end
      w_raw[K-1] = bus.pixel_in;
      w_taps     = '0;
      for (int j = 0; j < K; j++) begin
         if (int'(w_fill) + j >= K - 1) begin
            w_taps[tap_lsb(j, DW) +: DW] = w_raw[j];
         end else begin
`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
            w_taps[tap_lsb(j, DW) +: DW] = w_raw[w_rep_idx];
`else
            w_taps[tap_lsb(j, DW) +: DW] = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col        <= '0;
         r_row        <= '0;
         r_fill       <= '0;
         r_valid_out  <= 1'b0;
         r_taps       <= '0;
         r_col_out    <= '0;
         r_row_out    <= '0;
         r_rows_ready <= 1'b0;
         r_eol        <= 1'b0;
         r_eof        <= 1'b0;
      end else begin
         r_valid_out <= bus.valid_in;
         if (bus.valid_in) begin
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_fill       <= w_fill_nxt;
            r_taps       <= w_taps;
            r_col_out    <= w_col;
            r_row_out    <= w_row;
            r_rows_ready <= (w_fill == c_fill_full);
            r_eol        <= w_eol;
            r_eof        <= w_eof;
         end
      end
   end

   assign bus.valid_out      = r_valid_out;
   assign bus.taps_out       = r_taps;
   assign bus.col_out        = r_col_out;
   assign bus.row_out        = r_row_out;
   assign bus.rows_ready_out = r_rows_ready;
   assign bus.eol_out        = r_eol;
   assign bus.eof_out        = r_eof;
endmodule
`default_nettype wire

// File: tb/tb_multi_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_line_buffer
// Purpose  : Scoreboard bench for multi_line_buffer (W=H=4, K=3, DW=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_line_buffer;
   import line_buffer_pkg::*;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int K  = 3;
   localparam int TW = K * DW;

   typedef struct packed {
      logic [TW-1:0] taps;
      logic [1:0]    col;
      logic [1:0]    row;
      logic          rr;
      logic          eol;
      logic          eof;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multi_line_buffer_if #(.DW(DW), .W(W), .H(H), .K(K)) bus ();

   multi_line_buffer #(.DW(DW), .W(W), .H(H), .K(K)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t          sb [$];
   exp_t          last_exp;
   bit            have_last = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] img [H][W];
   int            m_row = 0;
   int            m_col = 0;

   task automatic check(input string name, input logic vg, input exp_t g,
                        input logic ve, input exp_t e);
      n_cmp++;
      if (vg !== ve || g !== e) begin
         n_bad++;
         $display("FAIL %s: got vld=%0b taps=%h col=%0d row=%0d rr=%0b eol=%0b eof=%0b, want vld=%0b taps=%h col=%0d row=%0d rr=%0b eol=%0b eof=%0b",
                  name, vg, g.taps, g.col, g.row, g.rr, g.eol, g.eof,
                  ve, e.taps, e.col, e.row, e.rr, e.eol, e.eof);
      end
   endtask

   always @(negedge clk) begin
      exp_t got;
      exp_t e;
      got = '{taps: bus.taps_out, col: bus.col_out, row: bus.row_out,
              rr: bus.rows_ready_out, eol: bus.eol_out, eof: bus.eof_out};
      if (!rst_n) begin
         have_last = 1'b0;
         check("reset", bus.valid_out, got, 1'b0, '0);
      end else if (bus.valid_out) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid: got valid_out=1, want no output pending");
         end else begin
            e = sb.pop_front();
            check("pixel", 1'b1, got, 1'b1, e);
            last_exp  = e;
            have_last = 1'b1;
         end
      end else if (have_last) begin
         check("hold", bus.valid_out, got, 1'b0, last_exp);
      end
   end

   // Hand rule for a row-0 pixel: zero pad above, or full replicate
   function automatic logic [TW-1:0] row0_taps(input logic [DW-1:0] p);
`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
      return {p, p, p};
`else
      return {p, 8'h00, 8'h00};
`endif
   endfunction

   task automatic idle(input int n, input logic sof_only);
      repeat (n) begin
         bus.sof_in = sof_only;
         @(posedge clk);
         #1;
      end
      bus.sof_in = 1'b0;
   endtask

   task automatic send(input logic sof, input logic [DW-1:0] pix,
                       input logic use_hand, input logic [TW-1:0] hand);
      exp_t e;
      int   d;
      if (sof) begin
         m_row = 0;
         m_col = 0;
      end
      e.row  = 2'(m_row);
      e.col  = 2'(m_col);
      e.rr   = (m_row >= K - 1);
      e.eol  = (m_col == W - 1);
      e.eof  = e.eol && (m_row == H - 1);
      e.taps = '0;
      for (int j = 0; j < K; j++) begin
         d = K - 1 - j;
         if (m_row >= d) begin
            e.taps[j*DW +: DW] = (d == 0) ? pix : img[m_row-d][m_col];
         end else begin
`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
            e.taps[j*DW +: DW] = (m_row == 0) ? pix : img[0][m_col];
`endif
         end
      end
      if (use_hand) e.taps = hand;
      img[m_row][m_col] = pix;
      if (m_col == W - 1) begin
         m_col = 0;
         m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
         m_col++;
      end
      sb.push_back(e);
      bus.sof_in   = sof;
      bus.valid_in = 1'b1;
      bus.pixel_in = pix;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      bus.sof_in   = 1'b0;
   endtask

   // Raster frame with pixel = 16*r+c; gaps toggles 1-0-1 then random idles
   task automatic send_frame(input int n_pix, input logic gaps);
      int            r;
      int            c;
      logic          uh;
      logic [TW-1:0] hv;
      for (int k = 0; k < n_pix; k++) begin
         r  = k / W;
         c  = k % W;
         uh = 1'b0;
         hv = '0;
         if (r == 2 && c == 1) begin uh = 1'b1; hv = 24'h211101; end
`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
         if (r == 0 && c == 1) begin uh = 1'b1; hv = 24'h010101; end
         if (r == 1 && c == 1) begin uh = 1'b1; hv = 24'h110101; end
`else
         if (r == 0 && c == 2) begin uh = 1'b1; hv = 24'h020000; end
         if (r == 1 && c == 3) begin uh = 1'b1; hv = 24'h130300; end
`endif
         send(k == 0, 8'(16 * r + c), uh, hv);
         if (gaps) begin
            if (k < 4) idle(1, 1'b0);
            else       idle($urandom_range(0, 3), k[0]);
         end
      end
   endtask

   initial begin
      bus.sof_in   = 1'b0;
      bus.valid_in = 1'b0;
      bus.pixel_in = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      send_frame(16, 1'b0);
      send(1'b0, 8'h5A, 1'b1, row0_taps(8'h5A));
      idle(3, 1'b0);

      send_frame(16, 1'b1);
      idle(2, 1'b0);

      for (int k = 0; k < 6; k++) send(k == 0, 8'(16 * (k / W) + k % W), 1'b0, '0);
      send(1'b1, 8'hA0, 1'b1, row0_taps(8'hA0));
      for (int k = 1; k < 12; k++) send(1'b0, 8'(8'hA0 + k), 1'b0, '0);
      idle(2, 1'b0);

      for (int k = 0; k < 9; k++) send(k == 0, 8'(16 * (k / W) + k % W), 1'b0, '0);
      idle(2, 1'b0);
      rst_n = 1'b0;
      idle(3, 1'b0);
      rst_n = 1'b1;
      m_row = 0;
      m_col = 0;
      send(1'b0, 8'h77, 1'b1, row0_taps(8'h77));
      for (int k = 1; k < 6; k++) send(1'b0, 8'(8'h77 + k), 1'b0, '0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      idle(2, 1'b0);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d outputs still pending, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
